// File: rtl/tach_gate_timer.sv
// Measurement-window generator for the encoder tachometer.
// Each window runs CLEAR (timer_reset), GATE (timer_on) and HOLD phases.
// Windows start on a start pulse or run back-to-back in continuous mode.
module tach_gate_timer #(
  parameter int unsigned GATE_W       = 32,
  parameter int unsigned HOLD_W       = 16,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              system_reset,
  input  logic              enable,
  input  logic              continuous,
  input  logic              start,
  input  logic              abort,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [HOLD_W-1:0] holdoff_cycles,
  output logic              timer_reset,
  output logic              timer_on,
  output logic              window_done,
  output logic              busy,
  output logic [CNT_W-1:0]  window_count
);

  // Clear counter only needs to hold CLEAR_CYCLES-1.
  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [GATE_W-1:0]   g_len_q, g_len_d;
  logic [HOLD_W-1:0]   h_len_q, h_len_d;
  logic [CNT_W-1:0]    count_d;
  logic                timer_reset_d;
  logic                timer_on_d;
  logic                window_done_d;
  logic                busy_d;
  logic                load_window;
  logic                run_cont;

  assign run_cont = enable & continuous;

  // Next-state, phase counters and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    g_len_d       = g_len_q;
    h_len_d       = h_len_q;
    count_d       = window_count;
    window_done_d = 1'b0;
    load_window   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start || run_cont) begin
          state_d     = ST_CLEAR;
          load_window = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d    = ST_GATE;
          // Count down from len-1 so all-ones lengths never overflow.
          gate_cnt_d = g_len_q - GATE_W'(1);
        end else begin
          clr_cnt_d = clr_cnt_q - CLR_W'(1);
        end
      end

      ST_GATE: begin
        if (gate_cnt_q == '0) begin
          state_d       = ST_HOLD;
          hold_cnt_d    = h_len_q - HOLD_W'(1);
          window_done_d = 1'b1;
          count_d       = window_count + CNT_W'(1);
        end else begin
          gate_cnt_d = gate_cnt_q - GATE_W'(1);
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == '0) begin
          if (run_cont) begin
            state_d     = ST_CLEAR;
            load_window = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Window lengths are frozen at CLEAR entry; zero means one cycle.
    if (load_window) begin
      g_len_d   = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
      h_len_d   = (holdoff_cycles == '0) ? HOLD_W'(1) : holdoff_cycles;
      clr_cnt_d = CLR_W'(CLEAR_CYCLES - 1);
    end

    // Abort cancels the window without completing or counting it.
    if (abort) begin
      state_d       = ST_IDLE;
      window_done_d = 1'b0;
      count_d       = window_count;
    end

    timer_reset_d = (state_d == ST_CLEAR);
    timer_on_d    = (state_d == ST_GATE);
    busy_d        = (state_d != ST_IDLE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q      <= ST_IDLE;
      clr_cnt_q    <= '0;
      gate_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      g_len_q      <= GATE_W'(1);
      h_len_q      <= HOLD_W'(1);
      timer_reset  <= 1'b0;
      timer_on     <= 1'b0;
      window_done  <= 1'b0;
      busy         <= 1'b0;
      window_count <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      gate_cnt_q   <= gate_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      g_len_q      <= g_len_d;
      h_len_q      <= h_len_d;
      timer_reset  <= timer_reset_d;
      timer_on     <= timer_on_d;
      window_done  <= window_done_d;
      busy         <= busy_d;
      window_count <= count_d;
    end
  end

endmodule
